// File: rtl/lifo_ext.sv
// lifo_ext: LIFO stack with occupancy flags, sticky overflow/underflow and optional show-ahead output.
module lifo_ext #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_EMPTY = 2,
  parameter int ALMOST_FULL  = 2,
  parameter int SHOWAHEAD    = 0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DWIDTH-1:0] data,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic              clr_err,
  output logic [DWIDTH-1:0] q,
  output logic              empty,
  output logic              full,
  output logic [AWIDTH:0]   usedw,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] FULL_LVL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_LVL   = (AWIDTH+1)'(DEPTH - ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_LVL   = (AWIDTH+1)'(ALMOST_EMPTY);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q, q_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [AWIDTH-1:0] top_idx, nxt_idx, wr_idx;
  logic              pop, repl, wr_en, grow, ovf_set, udf_set;
  assign empty        = usedw_q == '0;
  assign full         = usedw_q == FULL_LVL;
  assign almost_full  = usedw_q >= AF_LVL;
  assign almost_empty = usedw_q <= AE_LVL;
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign q            = q_q;
  always_comb begin
    top_idx = usedw_q[AWIDTH-1:0] - AWIDTH'(1);
    nxt_idx = usedw_q[AWIDTH-1:0] - AWIDTH'(2);
    pop     = rdreq && !wrreq && !empty;
    repl    = rdreq && wrreq && !empty;
    // a simultaneous push/pop on an empty stack degrades to a plain push
    grow    = wrreq && (rdreq ? empty : !full);
    wr_en   = grow || repl;
    wr_idx  = repl ? top_idx : usedw_q[AWIDTH-1:0];
    ovf_set = wrreq && !rdreq && full;
    udf_set = rdreq && empty;
    ovf_d   = ovf_set || (ovf_q && !clr_err);
    udf_d   = udf_set || (udf_q && !clr_err);
    usedw_d = grow ? usedw_q + (AWIDTH+1)'(1) : pop ? usedw_q - (AWIDTH+1)'(1) : usedw_q;
    // show-ahead keeps q equal to the new top; registered mode returns the old top
    q_d     = SHOWAHEAD != 0
            ? (wr_en ? data : (pop && usedw_q > (AWIDTH+1)'(1)) ? mem[nxt_idx] : q_q)
            : ((pop || repl) ? mem[top_idx] : q_q);
  end
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      usedw_q <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      usedw_q <= usedw_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= data;
  end
endmodule

// File: doc/lifo_ext.md
LIFO_EXT -- requirements
Module: lifo_ext

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 8, address width; DEPTH = 2**AWIDTH entries.
REQ-003 SHALL have parameter ALMOST_EMPTY, default 2, almost_empty threshold.
REQ-004 SHALL have parameter ALMOST_FULL, default 2, almost_full margin below DEPTH.
REQ-005 SHALL have parameter SHOWAHEAD, default 0; 0 = registered-read mode, 1 = show-ahead mode.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 SHALL have port srst, input, 1 bit, reset, asynchronous and active-high.
REQ-008 SHALL have port data, input, DWIDTH bits, push data.
REQ-009 SHALL have port wrreq, input, 1 bit, push request.
REQ-010 SHALL have port rdreq, input, 1 bit, pop request.
REQ-011 SHALL have port clr_err, input, 1 bit, clears sticky error flags.
REQ-012 SHALL have port q, output, DWIDTH bits, read data.
REQ-013 SHALL have port empty, output, 1 bit, usedw == 0.
REQ-014 SHALL have port full, output, 1 bit, usedw == DEPTH.
REQ-015 SHALL have port usedw, output, AWIDTH+1 bits, occupied entry count.
REQ-016 SHALL have port almost_full, output, 1 bit, usedw >= DEPTH - ALMOST_FULL.
REQ-017 SHALL have port almost_empty, output, 1 bit, usedw <= ALMOST_EMPTY.
REQ-018 SHALL have port overflow, output, 1 bit, sticky flag for a push rejected because the stack was full.
REQ-019 SHALL have port underflow, output, 1 bit, sticky flag for a pop rejected because the stack was empty.

Function
REQ-020 SHALL store up to DEPTH words; the last word pushed is the first word popped.
REQ-021 SHALL decode requests each cycle as follows:
- Push: wrreq=1, rdreq=0, not full -> write data at index usedw, usedw+1.
- Pop: rdreq=1, wrreq=0, not empty -> read top entry, usedw-1.
- Replace: wrreq=1, rdreq=1, not empty -> top entry is read, then overwritten with data; usedw unchanged; permitted when full, with no overflow.
- Both requested when empty -> push only, usedw becomes 1, underflow set.
REQ-022 SHALL ignore a push when full (no memory or usedw change) and set overflow the next cycle.
REQ-023 SHALL ignore a pop when empty (q unchanged) and set underflow the next cycle.
REQ-024 SHALL update usedw and all status flags on the clock edge that accepts the request; flags derive only from registered usedw.
REQ-025 SHALL, with SHOWAHEAD=0, drive q with the popped or replaced top word one cycle after the accepted rdreq, and hold q at all other times.
REQ-026 SHALL, with SHOWAHEAD=1, drive q from a registered copy of the current top entry, updated in the same cycle as usedw; q is valid whenever empty=0 and holds its last value when empty=1.
REQ-027 SHALL, with SHOWAHEAD=1, treat rdreq as a discard of the top word that q already shows; after a replace, q equals the new data.
REQ-028 SHALL keep overflow and underflow set until clr_err=1 is sampled; if clr_err and a new error occur in the same cycle, the error wins.
REQ-029 SHALL hold usedw in the range 0..DEPTH; usedw SHALL never wrap.
REQ-030 SHALL need no extra cycles or bubbles; back-to-back requests SHALL be accepted every cycle.

Reset
REQ-031 SHALL, on srst=1 at any time (including mid-operation), immediately force usedw=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, q=0, without waiting for a clock edge.
REQ-032 SHALL leave memory contents undefined after reset; entries SHALL not be readable until pushed again.
REQ-033 SHALL accept requests from the first rising edge after srst deasserts.

Verification (AWIDTH=3, DEPTH=8, ALMOST_FULL=2, ALMOST_EMPTY=2)
REQ-034 SHALL cover the fill/drain scenario: push 1..8, then one more push -> full=1, usedw=8, overflow=1; pop 8 times (SHOWAHEAD=0) -> q = 8,7,...,1, each one cycle after its rdreq; empty=1.
REQ-035 SHALL cover threshold transitions: almost_full rises when usedw reaches 6; almost_empty falls when usedw reaches 3 and rises again when it returns to 2.
REQ-036 SHALL cover replace: push 0xA,0xB, then wrreq=rdreq=1 with data=0xC -> q=0xB (SHOWAHEAD=0), usedw=2; next pop -> q=0xC.
REQ-037 SHALL cover errors: pop on empty -> underflow=1 and q unchanged; clr_err pulse -> underflow=0; clr_err in the same cycle as an empty pop -> underflow stays 1.
REQ-038 SHALL cover show-ahead: with SHOWAHEAD=1, push 0x5 then 0x6 -> q=0x6 without rdreq; one rdreq -> q=0x5.
REQ-039 SHALL cover async reset: assert srst between clock edges with usedw=5 -> usedw=0, empty=1, q=0 before the next edge; a push after release -> usedw=1.
